serial_shift_unit: RTL and testbench

- Parametrised successor to the team's 8-bit serial shift register: parallel load, bidirectional shifting, serial input and a bit counter.
- Sits beside the serial adder datapath. One instance serialises each operand, and a second instance deserialises the sum through ser_in.
- After a load it shifts exactly WIDTH bits and reports busy/done, so the adder controller needs no external bit counter.

---
 rtl/serial_shift_unit.sv | 76 +++++++
 tb/tb_serial_shift_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_unit.sv
// serial_shift_unit: parametrised parallel-load shift register with
// bidirectional shifting, serial input and a bit counter. After a load it
// shifts exactly WIDTH bits, then raises done for one cycle.
module serial_shift_unit #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       enable,
    input  logic                       dir,
    input  logic                       ser_in,
    output logic                       ser_out,
    output logic [WIDTH-1:0]           par_out,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic             w_last_shift;

    // Next register value for a shift in the currently requested direction.
    always_comb begin
        w_shifted = r_reg;
        if (dir) begin
            w_shifted = {r_reg[WIDTH-2:0], ser_in};
        end else begin
            w_shifted = {ser_in, r_reg[WIDTH-1:1]};
        end
    end

    assign w_last_shift = (r_count == CW'(WIDTH - 1));

    // Register, counter and status update: rst > load > shift > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg   <= RST_VAL;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_reg   <= data_in;
                r_count <= '0;
                r_busy  <= 1'b1;
            end else if (r_busy && enable) begin
                r_reg <= w_shifted;
                if (w_last_shift) begin
                    r_count <= CW'(WIDTH);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign ser_out = dir ? r_reg[WIDTH-1] : r_reg[0];
    assign par_out = r_reg;
    assign count   = r_count;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit (WIDTH=8). Expected serial bits and
// register values are queued when stimulus is driven and popped when the
// DUT produces them; status outputs are checked against constants.
module tb_serial_shift_unit;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data_in;
    logic       enable;
    logic       dir;
    logic       ser_in;
    logic       ser_out;
    logic [7:0] par_out;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];

    serial_shift_unit #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .enable  (enable),
        .dir     (dir),
        .ser_in  (ser_in),
        .ser_out (ser_out),
        .par_out (par_out),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] stream;
        logic [7:0] model;
        int n;

        rst = 1'b1; load = 1'b0; data_in = '0; enable = 1'b0; dir = 1'b0; ser_in = 1'b0;
        #1;

        // 1. reset
        tick(); tick();
        chk("rst_par", par_out, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // 2. right shift of 0xB4, LSB first
        d = 8'hB4;
        load = 1'b1; data_in = d; dir = 1'b0; ser_in = 1'b0; enable = 1'b1;
        for (int k = 0; k < 8; k++) sb_push({31'd0, d[k]});
        sb_push(32'h00);
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sb_check("r_ser_out", ser_out);
            chk("r_busy", busy, 1);
            chk("r_count", count, k);
            chk("r_done_early", done, 0);
            tick();
        end
        chk("r_done", done, 1);
        chk("r_busy_end", busy, 0);
        chk("r_count_end", count, 8);
        sb_check("r_par_end", par_out);
        tick();
        chk("r_done_clear", done, 0);

        // 3. left shift deserialise 1,0,1,0,0,1,1,1
        stream = 8'b1110_0101;
        model = 8'h00;
        for (int k = 0; k < 8; k++) model = {model[6:0], stream[k]};
        sb_push({24'd0, model});
        load = 1'b1; data_in = 8'h00; dir = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ser_in = stream[k];
            tick();
        end
        chk("l_done", done, 1);
        chk("l_par_const", par_out, 8'hA7);
        sb_check("l_par_model", par_out);
        chk("l_ser_out", ser_out, 1);
        tick();

        // 4. stall after 3 shifts for 5 cycles
        load = 1'b1; data_in = 8'h0F; dir = 1'b0; ser_in = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("s_count_hold", count, 3);
            chk("s_par_hold", par_out, 8'h01);
            chk("s_busy_hold", busy, 1);
            tick();
        end
        chk("s_count_after", count, 3);
        enable = 1'b1;
        n = 8;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (done) break;
        end
        chk("s_done", done, 1);
        chk("s_done_latency", n, 13);
        tick();

        // 5. abort by reload, then reset mid-transfer
        load = 1'b1; data_in = 8'hFF; dir = 1'b0; ser_in = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("a_count4", count, 4);
        load = 1'b1; data_in = 8'h81;
        tick();
        load = 1'b0;
        chk("a_count0", count, 0);
        chk("a_par", par_out, 8'h81);
        chk("a_busy", busy, 1);
        chk("a_no_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_no_done_run", done, 0);
        end
        chk("a_count5", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("a_rst_busy", busy, 0);
        chk("a_rst_done", done, 0);
        chk("a_rst_par", par_out, 8'h00);
        chk("a_rst_count", count, 0);
        tick();
        chk("a_rst_no_done", done, 0);

        // 6a. idle with enable held high after completion
        load = 1'b1; data_in = 8'h5A; dir = 1'b0; ser_in = 1'b1; enable = 1'b1;
        model = 8'h5A;
        for (int k = 0; k < 8; k++) model = {1'b1, model[7:1]};
        sb_push({24'd0, model});
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("i_done", done, 1);
        sb_check("i_par_end", par_out);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("i_par_hold", par_out, 8'hFF);
            chk("i_count_hold", count, 8);
            chk("i_done_low", done, 0);
        end

        // 6b. load in the same cycle as the final shift
        load = 1'b1; data_in = 8'h3C; ser_in = 1'b0; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("c_count7", count, 7);
        load = 1'b1; data_in = 8'hC3;
        tick();
        load = 1'b0;
        chk("c_done", done, 0);
        chk("c_par", par_out, 8'hC3);
        chk("c_count", count, 0);
        chk("c_busy", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
